bus_timer_bridge: RTL and testbench
===================================

BUS_TIMER_BRIDGE -- requirements
Module: bus_timer_bridge

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-003 SHALL have port adr, input, 32 bits: CPU byte address.
REQ-004 SHALL have port writedata, input, 32 bits: CPU store data.
REQ-005 SHALL have port MemWrite, input, 1 bit: CPU store strobe, one cycle per store.
REQ-006 SHALL have port dm_rdata, input, 32 bits: data-memory read data, combinational from dm_adr.
REQ-007 SHALL have port readdata, output, 32 bits: data returned to the CPU, combinational from adr.
REQ-008 SHALL have port dm_adr, output, 32 bits: equal to adr.
REQ-009 SHALL have port dm_wdata, output, 32 bits: equal to writedata.
REQ-010 SHALL have port dm_we, output, 1 bit: data-memory write enable.
REQ-011 SHALL have port irq, output, 1 bit: timer interrupt request.

Function
REQ-012 SHALL decode the RAM region as 0x0000_0000-0x0000_2FFF.
REQ-013 SHALL decode the timer registers as CTRL at 0x7F00, PRESET at 0x7F04 and COUNT at 0x7F08.
REQ-014 SHALL treat every other address as unmapped: reads return 0, writes are ignored.
REQ-015 SHALL drive dm_we = MemWrite AND RAM hit, forced to 0 while rst=0.
REQ-016 SHALL select readdata combinationally, with zero latency: dm_rdata on a RAM hit, the timer register on a timer hit, 0 otherwise.
REQ-017 SHALL lay out CTRL as: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM; bits[31:4] read 0.
REQ-018 SHALL make PRESET fully writable, and SHALL make COUNT read-only, ignoring writes to it.
REQ-019 SHALL apply a register write on the rising edge of the cycle in which MemWrite=1.
REQ-020 SHALL implement timer FSM states IDLE, LOAD, CNT and INT.
REQ-021 SHALL transition IDLE->LOAD when EN=1.
REQ-022 SHALL, in LOAD, set COUNT<=PRESET and transition to CNT.
REQ-023 SHALL, in CNT, on EN=0 go to IDLE with COUNT held.
REQ-024 SHALL, in CNT with EN=1 and COUNT>1, decrement COUNT.
REQ-025 SHALL, in CNT with EN=1 and COUNT<=1, set COUNT<=0, set the flag and go to INT.
REQ-026 SHALL, in INT under MODE 00, clear EN and go to IDLE, with the flag sticky until any CTRL or PRESET write clears it.
REQ-027 SHALL, in INT under MODE 01, go to LOAD and clear the flag on the next edge (one-cycle pulse).
REQ-028 SHALL drive irq = flag AND IM.
REQ-029 SHALL give a timeline of: CTRL write edge E0, LOAD at E1, COUNT=PRESET at E2, INT and flag at edge E(PRESET+2), with PRESET=0 giving the same as PRESET=1.
REQ-030 SHALL give an auto-reload period of PRESET+2 cycles.
REQ-031 SHALL let a PRESET write during CNT take effect only at the next LOAD.
REQ-032 SHALL, when a CPU CTRL write coincides with the INT-state EN clear, let the CPU write win.

Reset
REQ-033 SHALL, on the rst=0 edge, clear CTRL, PRESET, COUNT and the flag, and set the FSM to IDLE; irq=0 and dm_we=0 follow.
REQ-034 SHALL let reset mid-count abort immediately, with no irq produced.

Configuration
REQ-035 SHALL, with TC_AUTORELOAD_EN defined, implement MODE 01 as auto-reload.
REQ-036 SHALL, without TC_AUTORELOAD_EN, make CTRL[2:1] read 0 and ignore writes to it, so every expiry is one-shot.

Structure
REQ-037 SHALL place address-map constants, CTRL bit positions and the FSM state encodings in a shared package/header named bridge_pkg.
REQ-038 SHALL place the FSM, CTRL/PRESET/COUNT and the flag in sub-module timer_core, with the bridge doing decode and the readdata mux.

Verification
REQ-039 SHALL check a RAM access: store 0x1234_5678 to 0x0000_0010 -> dm_we=1 for 1 cycle; readdata then equals dm_rdata.
REQ-040 SHALL check unmapped access: write 0xFFFF_FFFF to 0x0000_5000 -> dm_we=0, no register changes; read returns 0.
REQ-041 SHALL check one-shot: PRESET=3, CTRL=0x9 -> COUNT reads 3,2,1,0; irq=1 from edge E5 and stays high; CTRL bit0 reads 0; a PRESET write drops irq.
REQ-042 SHALL check auto-reload (TC_AUTORELOAD_EN defined): PRESET=2, CTRL=0xB -> irq pulses 1 cycle every 4 cycles, three consecutive pulses.
REQ-043 SHALL check reset mid-count: PRESET=10, CTRL=0x9, rst=0 at COUNT=6 -> next cycle all registers 0, irq=0, and irq stays 0 for 20 cycles.
REQ-044 SHALL check stop and restart: clear EN at COUNT=4 -> COUNT holds 4; setting EN=1 again reloads PRESET.

Source files
------------

// File: rtl/bridge_pkg.sv
//------------------------------------------------------------------------------
// Module      : bridge_pkg
// Description : Address map, CTRL bit positions, timer FSM encoding and the
//               address decoder shared by bus_timer_bridge and timer_core.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bridge_pkg;

    // RAM starts at address 0, so only the upper bound needs comparing.
    localparam logic [31:0] c_ram_last    = 32'h0000_2FFF;
    localparam logic [31:0] c_ctrl_addr   = 32'h0000_7F00;
    localparam logic [31:0] c_preset_addr = 32'h0000_7F04;
    localparam logic [31:0] c_count_addr  = 32'h0000_7F08;

    localparam int c_ctrl_en       = 0;
    localparam int c_ctrl_mode_lsb = 1;
    localparam int c_ctrl_im       = 3;
    localparam int c_ctrl_width    = 4;

    localparam logic [1:0] c_mode_reload = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_t;

    typedef struct packed {
        logic ram;
        logic ctrl;
        logic preset;
        logic count;
    } decode_t;

    function automatic decode_t addr_decode(input logic [31:0] addr);
        decode_t d;
        d        = '0;
        d.ram    = (addr <= c_ram_last);
        d.ctrl   = (addr == c_ctrl_addr);
        d.preset = (addr == c_preset_addr);
        d.count  = (addr == c_count_addr);
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_timer_bridge_if.sv
//------------------------------------------------------------------------------
// Module      : bus_timer_bridge_if
// Description : CPU-side load/store bus plus the data-memory port of the bridge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_timer_bridge_if;

    logic [31:0] adr;
    logic [31:0] writedata;
    logic        MemWrite;
    logic [31:0] dm_rdata;
    logic [31:0] readdata;
    logic [31:0] dm_adr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic        irq;

    modport master (
        output adr, writedata, MemWrite, dm_rdata,
        input  readdata, dm_adr, dm_wdata, dm_we, irq
    );

    modport slave (
        input  adr, writedata, MemWrite, dm_rdata,
        output readdata, dm_adr, dm_wdata, dm_we, irq
    );

endinterface

`default_nettype wire

// File: rtl/timer_core.sv
//------------------------------------------------------------------------------
// Module      : timer_core
// Description : CTRL/PRESET/COUNT registers, expiry flag and the countdown FSM.
//               TC_AUTORELOAD_EN enables MODE 01 auto-reload.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_core
    import bridge_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    wr_ctrl,
    input  wire logic                    wr_preset,
    input  wire logic [31:0]             wdata,
    output logic      [c_ctrl_width-1:0] ctrl,
    output logic      [31:0]             preset,
    output logic      [31:0]             count,
    output logic                         irq
);

    timer_state_t r_state;
    timer_state_t w_state_nxt;
    logic         r_en;
    logic         r_im;
    logic [31:0]  r_preset;
    logic [31:0]  r_count;
    logic [31:0]  w_count_nxt;
    logic         r_flag;
    logic         w_flag_set;
    logic         w_flag_pulse_clr;
    logic         w_en_clr;
    logic         w_reload;

`ifdef TC_AUTORELOAD_EN
    logic [1:0]   r_mode;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode <= 2'b00;
        end else if (wr_ctrl) begin
            r_mode <= wdata[c_ctrl_mode_lsb +: 2];
        end
    end

    // MODE 1x behaves as one-shot.
    assign w_reload = (r_mode == c_mode_reload);

    always_comb begin
        ctrl                        = '0;
        ctrl[c_ctrl_en]             = r_en;
        ctrl[c_ctrl_mode_lsb +: 2]  = r_mode;
        ctrl[c_ctrl_im]             = r_im;
    end
`else
    assign w_reload = 1'b0;

    always_comb begin
        ctrl            = '0;
        ctrl[c_ctrl_en] = r_en;
        ctrl[c_ctrl_im] = r_im;
    end
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_flag_set       = 1'b0;
        w_flag_pulse_clr = 1'b0;
        w_en_clr         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_en) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!r_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    // PRESET of 0 expires exactly like PRESET of 1.
                    w_count_nxt = 32'd0;
                    w_flag_set  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                if (w_reload) begin
                    w_flag_pulse_clr = 1'b1;
                    w_state_nxt      = ST_LOAD;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_preset <= '0;
            r_en     <= 1'b0;
            r_im     <= 1'b0;
            r_flag   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // A CPU CTRL write takes priority over the one-shot EN clear.
            if (wr_ctrl) begin
                r_en <= wdata[c_ctrl_en];
                r_im <= wdata[c_ctrl_im];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end
            if (wr_preset) begin
                r_preset <= wdata;
            end
            if (w_flag_set) begin
                r_flag <= 1'b1;
            end else if (wr_ctrl || wr_preset || w_flag_pulse_clr) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign preset = r_preset;
    assign count  = r_count;
    assign irq    = r_flag & r_im;

endmodule

`default_nettype wire

// File: rtl/bus_timer_bridge.sv
//------------------------------------------------------------------------------
// Module      : bus_timer_bridge
// Description : Decodes CPU accesses between data RAM and the timer registers
//               and muxes read data. TC_AUTORELOAD_EN enables timer auto-reload.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_timer_bridge
    import bridge_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    bus_timer_bridge_if.slave  bus
);

    decode_t                 w_dec;
    logic                    w_wr_ctrl;
    logic                    w_wr_preset;
    logic [c_ctrl_width-1:0] w_ctrl;
    logic [31:0]             w_preset;
    logic [31:0]             w_count;
    logic                    w_irq;
    logic [31:0]             w_rdata;

    assign w_dec       = addr_decode(bus.adr);
    assign w_wr_ctrl   = bus.MemWrite & w_dec.ctrl;
    assign w_wr_preset = bus.MemWrite & w_dec.preset;

    timer_core u_timer_core (
        .clk       (clk),
        .rst       (rst),
        .wr_ctrl   (w_wr_ctrl),
        .wr_preset (w_wr_preset),
        .wdata     (bus.writedata),
        .ctrl      (w_ctrl),
        .preset    (w_preset),
        .count     (w_count),
        .irq       (w_irq)
    );

    always_comb begin
        w_rdata = '0;
        if (w_dec.ram) begin
            w_rdata = bus.dm_rdata;
        end else if (w_dec.ctrl) begin
            w_rdata = {{(32 - c_ctrl_width){1'b0}}, w_ctrl};
        end else if (w_dec.preset) begin
            w_rdata = w_preset;
        end else if (w_dec.count) begin
            w_rdata = w_count;
        end
    end

    assign bus.readdata = w_rdata;
    assign bus.dm_adr   = bus.adr;
    assign bus.dm_wdata = bus.writedata;
    // Gated by reset so no store reaches memory while the system is held.
    assign bus.dm_we    = bus.MemWrite & w_dec.ram & rst;
    assign bus.irq      = w_irq;

endmodule

`default_nettype wire

// File: tb/tb_bus_timer_bridge.sv
//------------------------------------------------------------------------------
// Module      : tb_bus_timer_bridge
// Description : Self-checking bench for bus_timer_bridge with a behavioural RAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_timer_bridge;

    localparam logic [31:0] c_ctrl   = 32'h7F00;
    localparam logic [31:0] c_preset = 32'h7F04;
    localparam logic [31:0] c_count  = 32'h7F08;
    localparam logic [31:0] c_idle   = 32'h5000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_timer_bridge_if bus();

    bus_timer_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:3071];
    assign bus.dm_rdata = (bus.dm_adr < 32'h3000) ? mem[bus.dm_adr[13:2]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (bus.dm_we && (bus.dm_adr < 32'h3000)) begin
            mem[bus.dm_adr[13:2]] <= bus.dm_wdata;
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    logic        exp_b;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] a);
        bus.adr = a;
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        bus.adr       = a;
        bus.writedata = d;
        bus.MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
        bus.adr       = c_idle;
        bus.writedata = '0;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.adr       = 32'h10;
        bus.writedata = 32'hAAAA_AAAA;
        bus.MemWrite  = 1'b1;
        #1;
        if (bus.dm_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_dm_we: got %b want 0", bus.dm_we);
        end
        n_checks++;
        tick();
        tick();
        bus.MemWrite = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            peek(c_ctrl + 32'(4 * i));
            exp_v = exp_q.pop_front();
            if (bus.readdata !== exp_v) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h want %h", i, bus.readdata, exp_v);
            end
            n_checks++;
        end
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b want 0", bus.irq);
        end
        n_checks++;
        rst = 1'b1;
        bus.adr = c_idle;
        tick();
    endtask

    task automatic test_ram();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        logic        wes   [3];
        addrs = '{32'h10, 32'h2FFC, 32'h3000};
        datas = '{32'h1234_5678, 32'hCAFE_F00D, 32'h5555_AAAA};
        wes   = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            bus.adr       = addrs[i];
            bus.writedata = datas[i];
            bus.MemWrite  = 1'b1;
            exp_q.push_back(wes[i] ? datas[i] : 32'h0);
            #1;
            if (bus.dm_we !== wes[i] || bus.dm_adr !== addrs[i] || bus.dm_wdata !== datas[i]) begin
                n_fail++;
                $display("FAIL ram_store%0d: got we=%b adr=%h wd=%h want we=%b adr=%h wd=%h",
                         i, bus.dm_we, bus.dm_adr, bus.dm_wdata, wes[i], addrs[i], datas[i]);
            end
            n_checks++;
            tick();
            bus.MemWrite = 1'b0;
            #1;
            if (bus.dm_we !== 1'b0) begin
                n_fail++; $display("FAIL ram_we_pulse%0d: got %b want 0", i, bus.dm_we);
            end
            n_checks++;
            exp_v = exp_q.pop_front();
            if (bus.readdata !== exp_v) begin
                n_fail++; $display("FAIL ram_read%0d: got %h want %h", i, bus.readdata, exp_v);
            end
            n_checks++;
        end
        bus.adr = c_idle;
    endtask

    task automatic test_unmapped();
        bus.adr       = c_idle;
        bus.writedata = 32'hFFFF_FFFF;
        bus.MemWrite  = 1'b1;
        #1;
        if (bus.dm_we !== 1'b0) begin
            n_fail++; $display("FAIL unmapped_we: got %b want 0", bus.dm_we);
        end
        n_checks++;
        tick();
        bus.MemWrite = 1'b0;
        cpu_write(c_count, 32'h55);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            peek(c_ctrl + 32'(4 * i));
            exp_v = exp_q.pop_front();
            if (bus.readdata !== exp_v) begin
                n_fail++; $display("FAIL unmapped_reg%0d: got %h want %h", i, bus.readdata, exp_v);
            end
            n_checks++;
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        peek(c_idle);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL unmapped_read: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        peek(32'h7F0C);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL unmapped_7f0c: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        bus.adr = c_idle;
    endtask

    task automatic test_oneshot();
        cpu_write(c_preset, 32'd3);
        cpu_write(c_ctrl, 32'h9);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(3 - k));
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            peek(c_count);
            exp_v = exp_q.pop_front();
            if (bus.readdata !== exp_v) begin
                n_fail++; $display("FAIL oneshot_count%0d: got %h want %h", k, bus.readdata, exp_v);
            end
            n_checks++;
            exp_b = (k == 3);
            if (bus.irq !== exp_b) begin
                n_fail++; $display("FAIL oneshot_irq%0d: got %b want %b", k, bus.irq, exp_b);
            end
            n_checks++;
            if (k < 3) tick();
        end
        tick();
        tick();
        tick();
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_sticky: got %b want 1", bus.irq);
        end
        n_checks++;
        exp_q.push_back(32'h8);
        peek(c_ctrl);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL oneshot_ctrl: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        cpu_write(c_preset, 32'd3);
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_clear: got %b want 0", bus.irq);
        end
        n_checks++;
        cpu_write(c_ctrl, 32'h6);
`ifdef TC_AUTORELOAD_EN
        exp_q.push_back(32'h6);
`else
        exp_q.push_back(32'h0);
`endif
        peek(c_ctrl);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL ctrl_mode_bits: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        cpu_write(c_ctrl, 32'h0);
    endtask

    task automatic test_preset_zero();
        cpu_write(c_preset, 32'd0);
        cpu_write(c_ctrl, 32'h9);
        tick();
        tick();
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL preset0_early: got %b want 0", bus.irq);
        end
        n_checks++;
        tick();
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL preset0_irq: got %b want 1", bus.irq);
        end
        n_checks++;
        cpu_write(c_ctrl, 32'h0);
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL preset0_clear: got %b want 0", bus.irq);
        end
        n_checks++;
    endtask

    task automatic test_ctrl_wins();
        cpu_write(c_preset, 32'd1);
        cpu_write(c_ctrl, 32'h9);
        tick();
        tick();
        tick();
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL wins_first_irq: got %b want 1", bus.irq);
        end
        n_checks++;
        cpu_write(c_ctrl, 32'h9);
        exp_q.push_back(32'h9);
        peek(c_ctrl);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v || bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL wins_ctrl: got ctrl=%h irq=%b want ctrl=%h irq=0", bus.readdata, bus.irq, exp_v);
        end
        n_checks++;
        tick();
        tick();
        tick();
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL wins_second_irq: got %b want 1", bus.irq);
        end
        n_checks++;
        cpu_write(c_ctrl, 32'h0);
    endtask

    task automatic test_autoreload();
        cpu_write(c_preset, 32'd2);
        cpu_write(c_ctrl, 32'hB);
        for (int c = 1; c <= 13; c++) begin
`ifdef TC_AUTORELOAD_EN
            exp_q.push_back({31'b0, (c == 4) || (c == 8) || (c == 12)});
`else
            exp_q.push_back({31'b0, (c >= 4)});
`endif
        end
        for (int c = 1; c <= 13; c++) begin
            tick();
            exp_v = exp_q.pop_front();
            if (bus.irq !== exp_v[0]) begin
                n_fail++; $display("FAIL reload_irq_e%0d: got %b want %b", c, bus.irq, exp_v[0]);
            end
            n_checks++;
        end
        cpu_write(c_ctrl, 32'h0);
        tick();
        tick();
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL reload_stop: got %b want 0", bus.irq);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        cpu_write(c_preset, 32'd10);
        cpu_write(c_ctrl, 32'h9);
        for (int i = 0; i < 6; i++) tick();
        exp_q.push_back(32'd6);
        peek(c_count);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL rstmid_count6: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            peek(c_ctrl + 32'(4 * i));
            exp_v = exp_q.pop_front();
            if (bus.readdata !== exp_v) begin
                n_fail++; $display("FAIL rstmid_reg%0d: got %h want %h", i, bus.readdata, exp_v);
            end
            n_checks++;
        end
        rst = 1'b1;
        bus.adr = c_idle;
        for (int i = 0; i < 20; i++) begin
            if (bus.irq !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_irq%0d: got %b want 0", i, bus.irq);
            end
            n_checks++;
            tick();
        end
    endtask

    task automatic test_stop_restart();
        cpu_write(c_preset, 32'd8);
        cpu_write(c_ctrl, 32'h9);
        for (int i = 0; i < 5; i++) tick();
        cpu_write(c_ctrl, 32'h8);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            peek(c_count);
            exp_v = exp_q.pop_front();
            if (bus.readdata !== exp_v) begin
                n_fail++; $display("FAIL stop_hold%0d: got %h want %h", i, bus.readdata, exp_v);
            end
            n_checks++;
        end
        cpu_write(c_ctrl, 32'h9);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd20);
        tick();
        peek(c_count);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL restart_load_cycle: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        tick();
        peek(c_count);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL restart_reload: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        tick();
        cpu_write(c_preset, 32'd20);
        peek(c_count);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL preset_during_cnt: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        peek(c_preset);
        exp_v = exp_q.pop_front();
        if (bus.readdata !== exp_v) begin
            n_fail++; $display("FAIL preset_readback: got %h want %h", bus.readdata, exp_v);
        end
        n_checks++;
        cpu_write(c_ctrl, 32'h0);
    endtask

    initial begin
        bus.adr       = c_idle;
        bus.writedata = '0;
        bus.MemWrite  = 1'b0;
        test_reset();
        test_ram();
        test_unmapped();
        test_oneshot();
        test_preset_zero();
        test_ctrl_wins();
        test_autoreload();
        test_reset_mid();
        test_stop_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
